// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and types for the memory-side responder of
//                the 32x8 test-to-memory bus.
//                  ADDR_W / DATA_W : default bus widths
//                  state_t         : responder access state
//                  addr_t / data_t : bus-width address and data types
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // State names the access sampled at the most recent rising edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_responder_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk   - clock
//                reset - asynchronous active-high clear
//                inc   - count one event on this rising edge
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the 32x8 test-to-memory bus.
//                Holds a DEPTH x DATA_W storage array, answers read/write
//                strobes sampled on the rising edge, returns read data one
//                clock later and tracks written status, a sticky collision
//                error and saturating access counters.
//  Ports       : clk, reset          - clock, async active-high reset
//                read, write         - access strobes
//                addr, data_in       - access address, write data
//                data_out            - registered read data
//                rd_valid            - pulse: data_out loaded by a read
//                uninit_rd           - pulse: that location never written
//                collision_err       - sticky: read and write seen together
//                rd_count, wr_count  - saturating accepted-access counts
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              uninit_rd,
    output logic              collision_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_rd_acc;
    logic              w_wr_acc;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DEPTH-1:0]  r_written;
    logic [DATA_W-1:0] r_data_out;
    logic              r_uninit;
    logic              r_collision;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state purely from the strobe pair; ERR needs no special
    // exit since every edge re-classifies the current access.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = IDLE;
        case ({read, write})
            2'b10:   w_state_nxt = READ;
            2'b01:   w_state_nxt = WRITE;
            2'b11:   w_state_nxt = ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The access that is about to be sampled drives the
    // datapath enables; the sampled access drives the read pulses.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_acc  = (w_state_nxt == READ);
        w_wr_acc  = (w_state_nxt == WRITE);
        rd_valid  = (r_state == READ);
        uninit_rd = (r_state == READ) && r_uninit;
    end

    // ------------------------------------------------------------------
    // Storage, written flags, read register and sticky collision flag.
    // A write commits on its own edge, so a read on the following edge
    // already sees the new value without any bypass path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written   <= '0;
            r_data_out  <= '0;
            r_uninit    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_data_out <= r_mem[addr];
                r_uninit   <= ~r_written[addr];
            end
            if (w_wr_acc) begin
                r_mem[addr]     <= data_in;
                r_written[addr] <= 1'b1;
            end
            if (w_state_nxt == ERR) begin
                r_collision <= 1'b1;
            end
        end
    end

    assign data_out      = r_data_out;
    assign collision_err = r_collision;

    // ------------------------------------------------------------------
    // Access counters
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_rd_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_rd_acc),
        .count (rd_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_wr_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wr_acc),
        .count (wr_count)
    );

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. A behavioural model
//                of the memory tracks expected outputs; a compare process
//                checks every output on each falling edge, and directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic        uninit_rd;
    logic        collision_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int tests;
    int fails;
    bit chk_en;

    // Behavioural model state
    logic [7:0] m_mem [32];
    bit         m_wr  [32];
    logic [7:0] m_dout;
    bit         m_rv;
    bit         m_un;
    bit         m_coll;
    int         m_rn;
    int         m_wn;

    mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .rd_valid      (rd_valid),
        .uninit_rd     (uninit_rd),
        .collision_err (collision_err),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat16(input int n);
        return (n > 65535) ? 65535 : n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 8'h00;
            m_wr[i]  = 1'b0;
        end
        m_dout = 8'h00;
        m_rv   = 1'b0;
        m_un   = 1'b0;
        m_coll = 1'b0;
        m_rn   = 0;
        m_wn   = 0;
    endtask

    // One bus cycle: drive at the falling edge, model the sampled access at
    // the rising edge, return at the next falling edge.
    task automatic cyc(input bit r, input bit w, input logic [4:0] a, input logic [7:0] d);
        read    = r;
        write   = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        m_rv = 1'b0;
        m_un = 1'b0;
        if (r && w) begin
            m_coll = 1'b1;
        end else if (r) begin
            m_dout = m_mem[a];
            m_rv   = 1'b1;
            m_un   = !m_wr[a];
            m_rn++;
        end else if (w) begin
            m_mem[a] = d;
            m_wr[a]  = 1'b1;
            m_wn++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        read  = 1'b0;
        write = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out",      {24'h0, data_out},  {24'h0, m_dout});
            chk("rd_valid",      {31'h0, rd_valid},  {31'h0, m_rv});
            chk("uninit_rd",     {31'h0, uninit_rd}, {31'h0, m_un});
            chk("collision_err", {31'h0, collision_err}, {31'h0, m_coll});
            chk("rd_count",      {16'h0, rd_count},  32'(sat16(m_rn)));
            chk("wr_count",      {16'h0, wr_count},  32'(sat16(m_wn)));
        end
    end

    initial begin
        int pulses;
        int uninits;
        tests   = 0;
        fails   = 0;
        chk_en  = 1'b0;
        reset   = 1'b1;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_counts",   {rd_count, wr_count}, 32'h0);

        // Read of a never-written location
        cyc(1, 0, 5'd5, 8'h00);
        chk("t1_data_out",  {24'h0, data_out}, 32'h00);
        chk("t1_rd_valid",  {31'h0, rd_valid}, 32'h1);
        chk("t1_uninit",    {31'h0, uninit_rd}, 32'h1);
        chk("t1_rd_count",  {16'h0, rd_count}, 32'h1);
        cyc(0, 0, 5'd0, 8'h00);
        chk("t1_idle_rv",   {31'h0, rd_valid}, 32'h0);
        chk("t1_idle_hold", {24'h0, data_out}, 32'h00);

        // Write then back-to-back read
        do_reset();
        cyc(0, 1, 5'd3, 8'hA5);
        chk("t2_wr_rv",     {31'h0, rd_valid}, 32'h0);
        cyc(1, 0, 5'd3, 8'h00);
        chk("t2_data_out",  {24'h0, data_out}, 32'hA5);
        chk("t2_uninit",    {31'h0, uninit_rd}, 32'h0);
        chk("t2_counts",    {rd_count, wr_count}, 32'h0001_0001);

        // Full sweep: write addr*3, read back everything
        do_reset();
        for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 8'(i * 3));
        pulses  = 0;
        uninits = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 5'(i), 8'h00);
            if (rd_valid)  pulses++;
            if (uninit_rd) uninits++;
            if (i == 31) chk("t3_last_data", {24'h0, data_out}, 32'h5D);
        end
        chk("t3_pulses",  32'(pulses),  32'd32);
        chk("t3_uninits", 32'(uninits), 32'd0);
        chk("t3_counts",  {rd_count, wr_count}, 32'h0020_0020);

        // Collision leaves memory and data_out untouched, flag sticks
        cyc(0, 1, 5'd3, 8'hA5);
        cyc(1, 0, 5'd3, 8'h00);
        chk("t4_rd_a5",     {24'h0, data_out}, 32'hA5);
        cyc(1, 1, 5'd3, 8'hFF);
        chk("t4_coll",      {31'h0, collision_err}, 32'h1);
        chk("t4_hold",      {24'h0, data_out}, 32'hA5);
        chk("t4_coll_rv",   {31'h0, rd_valid}, 32'h0);
        chk("t4_counts",    {rd_count, wr_count}, 32'h0021_0021);
        cyc(0, 0, 5'd0, 8'h00);
        cyc(1, 0, 5'd3, 8'h00);
        chk("t4_reread",    {24'h0, data_out}, 32'hA5);
        chk("t4_sticky",    {31'h0, collision_err}, 32'h1);

        // Held write strobe rewrites the same location every edge
        cyc(0, 1, 5'd7, 8'h11);
        cyc(0, 1, 5'd7, 8'h22);
        cyc(1, 0, 5'd7, 8'h00);
        chk("t5_rewrite",   {24'h0, data_out}, 32'h22);

        // Reset in the middle of a write burst
        for (int i = 0; i < 4; i++) cyc(0, 1, 5'(i), 8'hC0 + 8'(i));
        read    = 1'b0;
        write   = 1'b1;
        addr    = 5'd4;
        data_in = 8'hC4;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("t6_async_clr", {24'h0, data_out}, 32'h0);
        @(negedge clk);
        write = 1'b0;
        reset = 1'b0;
        chk("t6_counts",    {rd_count, wr_count}, 32'h0);
        chk("t6_coll",      {31'h0, collision_err}, 32'h0);
        cyc(1, 0, 5'd0, 8'h00);
        chk("t6_data",      {24'h0, data_out}, 32'h00);
        chk("t6_uninit",    {31'h0, uninit_rd}, 32'h1);

        // Held read strobe saturates the read counter
        for (int i = 0; i < 70000; i++) cyc(1, 0, 5'd0, 8'h00);
        chk("t7_sat",       {16'h0, rd_count}, 32'hFFFF);
        cyc(1, 0, 5'd1, 8'h00);
        chk("t7_no_wrap",   {16'h0, rd_count}, 32'hFFFF);
        chk("t7_wr_count",  {16'h0, wr_count}, 32'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side (responder) end of the 32x8 test-to-memory bus. Answers read/write strobes from the test side.
- Holds a 32-entry, 8-bit storage array and returns read data one clock after the request.
- Tracks per-location written status, sticky protocol errors, and saturating access counters for bench checking.
- Sits directly under the memory-side modport of the existing memory interface.

Parameters:
- ADDR_W, 5, address width
- DATA_W, 8, data width
- DEPTH, 32, number of locations (2**ADDR_W)
- CNT_W, 16, access counter width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- read  input  1  read strobe, sampled at posedge
- write  input  1  write strobe, sampled at posedge
- addr  input  ADDR_W  access address
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle pulse: data_out updated by a read this cycle
- uninit_rd  output  1  one-cycle pulse alongside rd_valid: the location read was never written since reset
- collision_err  output  1  sticky: read and write were sampled high together
- rd_count  output  CNT_W  saturating count of accepted reads
- wr_count  output  CNT_W  saturating count of accepted writes

Behaviour:
- Reset (async, active-high; takes effect immediately, including mid-access):
  - all storage cleared to 0; all written flags cleared.
  - data_out=0, rd_valid=0, uninit_rd=0, collision_err=0, rd_count=0, wr_count=0.
  - FSM forced to IDLE.
- FSM states: IDLE, READ, WRITE, ERR. The state reflects the access sampled at the last posedge.
  - read&!write -> READ
  - write&!read -> WRITE
  - read&write -> ERR
  - neither -> IDLE
  - ERR is left on the next cycle with a legal strobe combination; collision_err stays set.
- Read (read=1, write=0 at posedge):
  - data_out <= mem[addr]; rd_valid=1 for exactly that cycle.
  - uninit_rd=1 if written[addr]==0.
  - rd_count increments.
  - Latency is 1 clock: data is stable well before the test side samples it (7 ns after drive, 10 ns clock).
- Write (write=1, read=0 at posedge):
  - mem[addr] <= data_in; written[addr] <= 1; wr_count increments.
  - data_out holds its previous value; rd_valid=0.
- Idle (both strobes low): no state change except the FSM; data_out holds.
- Collision (both strobes high):
  - no memory update, no counter update; data_out holds.
  - collision_err set (sticky until reset); rd_valid=0.
- Back-to-back accesses: write to A at edge N, then read of A at edge N+1, returns the new data. No bypass is needed because the write has already committed.
- Strobes held high over multiple cycles: each posedge counts as one new access. A repeated write rewrites the location; a repeated read re-reads it.
- Counters saturate at all-ones (16'hFFFF) and never wrap.
- Address range is full 0..31; no out-of-range case exists. Address wrap is the natural 5-bit width.

Decomposition:
- Package mem_pkg:
  - ADDR_W and DATA_W constants.
  - typedef enum for the FSM states {IDLE, READ, WRITE, ERR}.
  - typedefs addr_t and data_t.
- Sub-module sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated twice for rd_count and wr_count.

Test Plan:
- Reset then read addr 5 -> data_out=8'h00, rd_valid=1, uninit_rd=1, rd_count=1.
- Write 8'hA5 to addr 3, read addr 3 next cycle -> data_out=8'hA5 one clock after the read, uninit_rd=0, wr_count=1, rd_count=1.
- Write 0..31 with data=addr*3, then read all 32 -> every value matches, 32 rd_valid pulses, uninit_rd never set, counts 32/32.
- Read addr 3 (8'hA5), then read=1 and write=1 with data_in=8'hFF at addr 3 -> collision_err=1, data_out stays 8'hA5; a later read of addr 3 still returns 8'hA5; collision_err remains 1.
- Assert reset mid-write burst (after 4 writes), release, read addr 0 -> data_out=0, uninit_rd=1, all counters and collision_err 0.
- Hold read=1 for 70000 cycles -> rd_count saturates at 16'hFFFF with no wrap.
